// File: rtl/lpm_pkg.sv
// ---------------------------------------------------------------------------
// lpm_pkg
//   Shared definitions for the LPM arithmetic primitives.
//   - rep_e        : operand interpretation (signed / unsigned)
//   - full_width() : natural width of an A x B product
//   - extend()     : sign- or zero-extend the low from_w bits of a wide word
//   MAX_W bounds every internal operand and product width.
// ---------------------------------------------------------------------------
package lpm_pkg;

  localparam int MAX_W = 128;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic {
    REP_SIGNED   = 1'b0,
    REP_UNSIGNED = 1'b1
  } rep_e;

  typedef logic [MAX_W-1:0] wide_t;

  function automatic int full_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  // Treat v[from_w-1:0] as the meaningful value and fill every bit above it
  // with the sign bit (signed) or with zeros (unsigned). The caller narrows
  // the returned word with a size cast, so this one helper serves both
  // extension and truncation.
  function automatic wide_t extend(input wide_t v, input int from_w, input rep_e rep);
    wide_t            r;
    logic [IDX_W-1:0] msb;
    msb = IDX_W'(from_w - 1);
    r   = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < from_w) r[i] = v[i];
      else            r[i] = (rep == REP_SIGNED) ? v[msb] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/lpm_pipe_reg.sv
// ---------------------------------------------------------------------------
// lpm_pipe_reg
//   DEPTH-stage register chain with asynchronous clear and clock enable.
//   Ports:
//     clock  in   rising-edge clock
//     aclr   in   asynchronous clear, active-high; zeroes every stage at once
//     clken  in   clock enable; all stages advance together or all hold
//     d_i    in   WIDTH  value entering stage 0
//     q_o    out  WIDTH  value leaving the last stage
// ---------------------------------------------------------------------------
module lpm_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clken,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: these are pipeline flops rather than a RAM, so clearing every entry
  // on reset is intended. Non-blocking updates let each stage capture its
  // predecessor's old value on the same edge.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (clken) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lpm_mult_core.sv
// ---------------------------------------------------------------------------
// lpm_mult_core
//   Parameterised multiplier: result = dataa * datab, with optional output
//   pipelining. The full product is LPM_WIDTHA+LPM_WIDTHB bits wide. It is
//   truncated to, or sign/zero-extended to, LPM_WIDTHP bits according to
//   LPM_REPRESENTATION.
//   Optional feature: define LPM_MULT_SUM_EN to add `sum`, extended to full
//   width, to the product before the pipeline registers. Without the macro,
//   `sum` is ignored.
//   Ports:
//     clock   in   rising-edge clock (unused when LPM_PIPELINE == 0)
//     aclr    in   asynchronous clear, active-high, for the pipeline stages
//     clken   in   clock enable for the pipeline stages
//     dataa   in   LPM_WIDTHA multiplicand
//     datab   in   LPM_WIDTHB multiplier
//     sum     in   LPM_WIDTHS addend
//     result  out  LPM_WIDTHP product
// ---------------------------------------------------------------------------
module lpm_mult_core
  import lpm_pkg::*;
#(
  parameter int    LPM_WIDTHA         = 8,
  parameter int    LPM_WIDTHB         = 8,
  parameter int    LPM_WIDTHP         = 16,
  parameter int    LPM_WIDTHS         = 1,
  parameter int    LPM_PIPELINE       = 0,
  parameter string LPM_REPRESENTATION = "SIGNED",
  parameter string LPM_HINT           = "UNUSED",
  parameter string LPM_TYPE           = "LPM_MULT"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clken,
  input  logic [LPM_WIDTHA-1:0] dataa,
  input  logic [LPM_WIDTHB-1:0] datab,
  input  logic [LPM_WIDTHS-1:0] sum,
  output logic [LPM_WIDTHP-1:0] result
);

  localparam int   FW  = full_width(LPM_WIDTHA, LPM_WIDTHB);
  localparam rep_e REP = (LPM_REPRESENTATION == "UNSIGNED") ? REP_UNSIGNED : REP_SIGNED;

  localparam bit PARAMS_OK =
      (LPM_WIDTHA >= 1) && (LPM_WIDTHB >= 1) && (LPM_WIDTHP >= 1) &&
      (LPM_WIDTHS >= 1) && (LPM_PIPELINE >= 0) &&
      (FW <= MAX_W) && (LPM_WIDTHP <= MAX_W) && (LPM_WIDTHS <= MAX_W) &&
      ((LPM_REPRESENTATION == "SIGNED") || (LPM_REPRESENTATION == "UNSIGNED"));

  if (!PARAMS_OK) begin : g_bad_params
    $error("lpm_mult_core (%s, hint %s): illegal width, pipeline or representation",
           LPM_TYPE, LPM_HINT);
  end

  logic [FW-1:0]         a_f;
  logic [FW-1:0]         b_f;
  logic [FW-1:0]         full_f;
  logic [LPM_WIDTHP-1:0] product_d;

  // Both operands are extended to the full product width first. A multiply
  // at that width is then exact, because the true product always fits in
  // FW bits, and one unsigned '*' covers both representations.
  // NOTE: every signal here is assigned on every pass through the block, so
  // no latch can be inferred. Blocking assignments are correct in
  // combinational logic.
  always_comb begin
    a_f = FW'(extend(wide_t'(dataa), LPM_WIDTHA, REP));
    b_f = FW'(extend(wide_t'(datab), LPM_WIDTHB, REP));
`ifdef LPM_MULT_SUM_EN
    full_f = (a_f * b_f) + FW'(extend(wide_t'(sum), LPM_WIDTHS, REP));
`else
    full_f = a_f * b_f;
`endif
    product_d = LPM_WIDTHP'(extend(wide_t'(full_f), FW, REP));
  end

`ifndef LPM_MULT_SUM_EN
  logic unused_sum;
  assign unused_sum = ^sum;
`endif

  if (LPM_PIPELINE > 0) begin : g_pipe
    lpm_pipe_reg #(
      .WIDTH(LPM_WIDTHP),
      .DEPTH(LPM_PIPELINE)
    ) u_pipe (
      .clock(clock),
      .aclr (aclr),
      .clken(clken),
      .d_i  (product_d),
      .q_o  (result)
    );
  end else begin : g_comb
    // The combinational build has no state, so the clock controls go nowhere.
    logic unused_ctrl;
    assign unused_ctrl = ^{clock, aclr, clken};
    assign result      = product_d;
  end

endmodule

// File: tb/tb_lpm_mult_core.sv
// Scoreboard bench for lpm_mult_core. Stimulus pushes hand-computed results
// into a queue and then signals the monitor. The monitor pops each entry and
// compares it against the output of the DUT the entry names.
module tb_lpm_mult_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aclr;
  logic       clken_q;
  logic [7:0] a8, b8, sum8;
  logic [15:0] a16, b16;
  logic [3:0] a4, b4;
  logic [7:0] pa, pb, qa, qb;

  logic [7:0]  r0;
  logic [15:0] r1, r2, r3, r5, r6, r7;
  logic [11:0] r4;

  // d0: signed 8x8 -> 8, combinational
  lpm_mult_core #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(8), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(0), .LPM_REPRESENTATION("SIGNED")) u_d0 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(a8), .datab(b8), .sum(1'b0), .result(r0));
  // d1: signed 16x16 -> 16 (packed-operand use)
  lpm_mult_core #(.LPM_WIDTHA(16), .LPM_WIDTHB(16), .LPM_WIDTHP(16), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(0), .LPM_REPRESENTATION("SIGNED")) u_d1 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(a16), .datab(b16), .sum(1'b0), .result(r1));
  // d2: unsigned 8x8 -> 16
  lpm_mult_core #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(0), .LPM_REPRESENTATION("UNSIGNED")) u_d2 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(a8), .datab(b8), .sum(1'b0), .result(r2));
  // d3: signed 8x8 -> 16
  lpm_mult_core #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(0), .LPM_REPRESENTATION("SIGNED")) u_d3 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(a8), .datab(b8), .sum(1'b0), .result(r3));
  // d4: signed 4x4 -> 12 (result wider than full product)
  lpm_mult_core #(.LPM_WIDTHA(4), .LPM_WIDTHB(4), .LPM_WIDTHP(12), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(0), .LPM_REPRESENTATION("SIGNED")) u_d4 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(a4), .datab(b4), .sum(1'b0), .result(r4));
  // d5: unsigned 8x8 -> 16 with an 8-bit addend
  lpm_mult_core #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_WIDTHS(8),
                  .LPM_PIPELINE(0), .LPM_REPRESENTATION("UNSIGNED")) u_d5 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(a8), .datab(b8), .sum(sum8), .result(r5));
  // d6: signed 8x8 -> 16, two pipeline stages
  lpm_mult_core #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(2), .LPM_REPRESENTATION("SIGNED")) u_d6 (
    .clock(clk), .aclr(aclr), .clken(1'b1), .dataa(pa), .datab(pb), .sum(1'b0), .result(r6));
  // d7: signed 8x8 -> 16, one pipeline stage with a controllable enable
  lpm_mult_core #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_WIDTHS(1),
                  .LPM_PIPELINE(1), .LPM_REPRESENTATION("SIGNED")) u_d7 (
    .clock(clk), .aclr(aclr), .clken(clken_q), .dataa(qa), .datab(qb), .sum(1'b0), .result(r7));

  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t  sb_q[$];
  event check_ev;
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] actual_of(input int id);
    case (id)
      0:       return 32'(r0);
      1:       return 32'(r1);
      2:       return 32'(r2);
      3:       return 32'(r3);
      4:       return 32'(r4);
      5:       return 32'(r5);
      6:       return 32'(r6);
      7:       return 32'(r7);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drains the scoreboard every time stimulus says outputs are valid.
  initial begin
    forever begin
      @(check_ev);
      while (sb_q.size() != 0) begin
        sb_t e;
        logic [31:0] act;
        e   = sb_q.pop_front();
        act = actual_of(e.id);
        n_vec++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: dut d%0d result=0x%0h expected=0x%0h", e.name, e.id, act, e.exp);
        end
      end
    end
  end

  task automatic expect_now(input int id, input logic [31:0] exp, input string name);
    sb_t e;
    e.id   = id;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    -> check_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; clken_q = 1'b1;
    a8 = '0; b8 = '0; sum8 = '0; a16 = '0; b16 = '0; a4 = '0; b4 = '0;
    pa = '0; pb = '0; qa = '0; qb = '0;
    #12;
    aclr = 1'b0;
    #1;
    expect_now(6, 32'h0, "reset_d6");
    expect_now(7, 32'h0, "reset_d7");

    // Combinational signed/unsigned products, truncation and extension.
    a8 = 8'hFD; b8 = 8'd5; #1;              // -3 * 5 = -15
    expect_now(0, 32'hF1, "s8x8_8_neg");
    a8 = 8'd16; b8 = 8'd16; #1;             // 256 wraps to 0 in 8 bits
    expect_now(0, 32'h00, "s8x8_8_trunc");
    a8 = 8'd0; b8 = 8'h80; #1;              // zero operand
    expect_now(0, 32'h00, "s8x8_8_zero");
    a8 = 8'hFF; b8 = 8'hFF; #1;
    expect_now(2, 32'hFE01, "u8x8_16_max");
    expect_now(3, 32'h0001, "s8x8_16_m1m1");
    a8 = 8'h80; b8 = 8'h80; #1;             // -128 * -128 = 16384
    expect_now(3, 32'h4000, "s8x8_16_minmin");
    a16 = {8'd12, 8'd7}; b16 = {7'd0, 1'b1, 7'd0, 1'b1}; #1;
    expect_now(1, 32'h1307, "pack_add");    // upper byte 19 = 12 + 7
    b16 = {7'd0, 1'b0, 7'd0, 1'b1}; #1;
    expect_now(1, 32'h0C07, "pack_sel");    // upper byte 12
    a4 = 4'h8; b4 = 4'd7; #1;               // -8 * 7 = -56, sign-extended
    expect_now(4, 32'hFC8, "s4x4_12_ext");
    a8 = 8'd6; b8 = 8'd7; sum8 = 8'd3; #1;
`ifdef LPM_MULT_SUM_EN
    expect_now(5, 32'd45, "sum_add");
`else
    expect_now(5, 32'd42, "sum_ignored");
`endif

    // Two-stage pipeline fill.
    pa = 8'd3; pb = 8'd4;
    tick();
    expect_now(6, 32'd0, "pipe2_not_full");
    pa = 8'd5; pb = 8'd6;
    tick();
    expect_now(6, 32'd12, "pipe2_first");
    pa = 8'd0; pb = 8'd0;
    tick();
    expect_now(6, 32'd30, "pipe2_second");

    // Single stage: async clear mid-cycle, then enable gating.
    qa = 8'd6; qb = 8'd7;
    tick();
    expect_now(7, 32'd42, "pipe1_load");
    aclr = 1'b1;
    #1;
    expect_now(7, 32'd0, "pipe1_aclr");
    aclr = 1'b0;
    clken_q = 1'b0; qa = 8'd2; qb = 8'd3;
    tick();
    tick();
    expect_now(7, 32'd0, "pipe1_hold");
    clken_q = 1'b1;
    tick();
    expect_now(7, 32'd6, "pipe1_resume");

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      n_fail += sb_q.size();
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lpm_mult_core.md
Name: lpm_mult_core

Overview:
Parameterised integer multiplier that computes result = dataa × datab, with optional latency pipelining. Project-wide multiplier primitive; wrapped by small arithmetic helpers that use it as adder or mux (packing operands into a wide word and multiplying by 0/1 selectors). Must be bit-exact with the wrapper's behavioural model.

Parameters:
LPM_WIDTHA, 8, width of dataa (≥1)
LPM_WIDTHB, 8, width of datab (≥1)
LPM_WIDTHP, 16, width of result (≥1)
LPM_WIDTHS, 1, width of sum input (only used when LPM_MULT_SUM_EN defined)
LPM_PIPELINE, 0, number of register stages on the output path; 0 = purely combinational
LPM_REPRESENTATION, "SIGNED", "SIGNED" or "UNSIGNED" operand interpretation
LPM_HINT, "UNUSED", synthesis hint string; no functional effect
LPM_TYPE, "LPM_MULT", identification string; no functional effect

Ports:
clock   input  1            rising-edge clock; ignored when LPM_PIPELINE=0
aclr    input  1            asynchronous reset, active-high; clears all pipeline stages
clken   input  1            clock enable, active-high; gates all pipeline stage updates
dataa   input  LPM_WIDTHA   multiplicand
datab   input  LPM_WIDTHB   multiplier
sum     input  LPM_WIDTHS   addend (only with LPM_MULT_SUM_EN)
result  output LPM_WIDTHP   product

Behaviour:
- Full product: width LPM_WIDTHA+LPM_WIDTHB; operands sign-extended when SIGNED, zero-extended when UNSIGNED.
- Result width:
  - LPM_WIDTHP < full width: result = least-significant LPM_WIDTHP bits of the product (wrap-around, no saturation).
  - LPM_WIDTHP > full width: sign-extend (SIGNED) or zero-extend (UNSIGNED).
- Zero operand: any operand equal to 0 gives result exactly 0.
- LPM_PIPELINE=0: result is a combinational function of the inputs; clock, aclr and clken are ignored.
- LPM_PIPELINE=N>0:
  - N-deep register chain after the combinational product.
  - On each rising clock with clken=1, every stage advances; result = value computed from inputs sampled N enabled edges earlier.
  - clken=0: all stages hold.
- aclr=1, any time (including mid-pipeline): all stages go to 0 immediately and result=0.
  - Release is synchronous-safe: first capture occurs on the first rising clock with aclr=0 and clken=1.
- Reset value of result: 0 for any N>0.
- Simultaneous aclr and clock edge: aclr wins.
- Illegal parameters (width 0, bad representation string): simulation $error at elaboration.

Optional Feature:
Macro LPM_MULT_SUM_EN.
- Defined: result = truncate/extend(dataa×datab + sum).
  - sum is extended per LPM_REPRESENTATION to full width before addition.
  - Addition occurs before the pipeline registers.
- Not defined: sum port exists but is ignored; result = product only.

Decomposition:
- Shared package lpm_pkg:
  - representation enum (REP_SIGNED, REP_UNSIGNED)
  - full-width calculation function
  - extend/truncate helper function
- One natural sub-module: lpm_pipe_reg, a parameterised N-stage register chain with aclr/clken.
  - Instantiated only when LPM_PIPELINE>0; generate bypass otherwise.

Test Plan:
1. SIGNED, 8×8→8, pipeline 0: dataa=-3, datab=5 -> result=8'hF1 (-15) combinationally; dataa=16, datab=16 -> result=8'h00 (truncated).
2. SIGNED, 16×16→16 packing: dataa={8'd12, 8'd7}, datab={7'd0,1'b1,7'd0,1'b1} -> result[15:8]=8'd19 (12+7); with datab={7'd0,1'b0,7'd0,1'b1} -> result[15:8]=8'd12.
3. UNSIGNED, 8×8→16: dataa=255, datab=255 -> result=16'hFE01; SIGNED same inputs -> 16'h0001.
4. LPM_PIPELINE=2, clken=1: apply 3×4 then 5×6 on consecutive edges -> result=12 two edges after the first, 30 on the next edge; result=0 before the pipeline fills after reset.
5. LPM_PIPELINE=1: assert aclr between clock edges while result=42 -> result=0 immediately without a clock; with clken=0, input changes never propagate.
6. With LPM_MULT_SUM_EN: dataa=6, datab=7, sum=3 -> result=45; without the macro -> result=42.
